// File: rtl/contador_de_programa_pkg.sv
// Shared processor constants: PC width, ALU op codes, fetch-sequencer states.
// Imported by the ALU, decoder and program counter.
package pacote_processador;

   localparam int LARGURA_PC_PADRAO = 16;

   localparam logic [4:0] OP_BEQ   = 5'b01001;
   localparam logic [4:0] OP_BNE   = 5'b01010;
   localparam logic [4:0] OP_PARAR = 5'b10101;

   typedef enum logic [1:0] {
      BUSCA,
      EXECUTA,
      PARADO
   } estado_t;

   function automatic logic eh_desvio(input logic [4:0] op);
      return (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/contador_de_programa_pilha_retorno.sv
// Return-address LIFO, PROF entries; top of stack readable combinationally, push/pop take one edge.
// Full/empty are flags only: push when full and pop when empty are dropped here.
module pilha_retorno #(
   parameter int LARGURA = 16,
   parameter int PROF    = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [LARGURA-1:0] dado_in,
   output logic [LARGURA-1:0] dado_out,
   output logic               cheia,
   output logic               vazia
);

   localparam int LP = $clog2(PROF + 1);
   localparam int LI = $clog2(PROF);

   logic [LARGURA-1:0] mem [PROF];
   logic [LP-1:0]      sp;
   logic [LI-1:0]      idx_escrita;
   logic [LI-1:0]      idx_topo;

   assign idx_escrita = LI'(sp);
   assign idx_topo    = LI'(sp - LP'(1));
   assign cheia       = (sp == LP'(PROF));
   assign vazia       = (sp == '0);
   assign dado_out    = mem[idx_topo];

   always_ff @(posedge clock) begin
      if (!reset) begin
         sp <= '0;
      end else if (push && !cheia) begin
         mem[idx_escrita] <= dado_in;
         sp               <= sp + LP'(1);
      end else if (pop && !vazia) begin
         sp <= sp - LP'(1);
      end
   end

endmodule

// File: rtl/contador_de_programa.sv
// Program counter / fetch sequencer: BUSCA then EXECUTA, 2 cycles min per instruction; pausa holds EXECUTA,
// instr_valida gates BUSCA, halt op freezes until reset. Return stack built only with PILHA_RETORNO_EN.
module contador_de_programa
   import pacote_processador::*;
#(
   parameter int                    LARGURA_PC = LARGURA_PC_PADRAO,
   parameter logic [LARGURA_PC-1:0] PC_INICIAL = '0,
   parameter int                    PROF_PILHA = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [4:0]            controle_ula,
   input  logic [LARGURA_PC-1:0] branch,
   input  logic [LARGURA_PC-1:0] endereco_salto,
   input  logic                  salto,
   input  logic                  chama,
   input  logic                  retorna,
   input  logic                  instr_valida,
   input  logic                  pausa,
   output logic [LARGURA_PC-1:0] pc,
   output logic                  busca,
   output logic                  executa,
   output logic                  parado,
   output logic                  erro_pilha,
   output logic [15:0]           instrucoes
);

   estado_t               estado;
   logic [LARGURA_PC-1:0] pc_q;
   logic [LARGURA_PC-1:0] pc_mais_um;
   logic [LARGURA_PC-1:0] pc_prox;
   logic                  busca_q;
   logic                  executa_q;
   logic                  parado_q;
   logic [15:0]           instrucoes_q;

   assign pc_mais_um = pc_q + LARGURA_PC'(1);

`ifdef PILHA_RETORNO_EN
   logic                  pilha_push;
   logic                  pilha_pop;
   logic                  pilha_erro;
   logic                  pilha_cheia;
   logic                  pilha_vazia;
   logic [LARGURA_PC-1:0] pilha_dado;
   logic                  conclui;
   logic                  erro_q;

   // Stack only moves when the instruction actually retires with a non-halt op.
   assign conclui = (estado == EXECUTA) && !pausa && (controle_ula != OP_PARAR);

   pilha_retorno #(
      .LARGURA (LARGURA_PC),
      .PROF    (PROF_PILHA)
   ) u_pilha (
      .clock    (clock),
      .reset    (reset),
      .push     (conclui && pilha_push),
      .pop      (conclui && pilha_pop),
      .dado_in  (pc_mais_um),
      .dado_out (pilha_dado),
      .cheia    (pilha_cheia),
      .vazia    (pilha_vazia)
   );

   always_comb begin
      pc_prox    = pc_mais_um;
      pilha_push = 1'b0;
      pilha_pop  = 1'b0;
      pilha_erro = 1'b0;
      if (eh_desvio(controle_ula)) begin
         pc_prox = branch;
      end else if (retorna) begin
         if (pilha_vazia) begin
            pilha_erro = 1'b1;
         end else begin
            pc_prox   = pilha_dado;
            pilha_pop = 1'b1;
         end
      end else if (chama) begin
         pc_prox = endereco_salto;
         if (pilha_cheia) pilha_erro = 1'b1;
         else             pilha_push = 1'b1;
      end else if (salto) begin
         pc_prox = endereco_salto;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset)                       erro_q <= 1'b0;
      else if (conclui && pilha_erro)   erro_q <= 1'b1;
   end

   assign erro_pilha = erro_q;
`else
   logic retorna_unused;

   assign retorna_unused = retorna & (PROF_PILHA > 0);

   always_comb begin
      pc_prox = pc_mais_um;
      if (eh_desvio(controle_ula))  pc_prox = branch;
      else if (chama || salto)      pc_prox = endereco_salto;
   end

   assign erro_pilha = 1'b0;
`endif

   // busca drops for the first cycle after reset; a fetch is accepted only while busca is up.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado       <= BUSCA;
         pc_q         <= PC_INICIAL;
         busca_q      <= 1'b0;
         executa_q    <= 1'b0;
         parado_q     <= 1'b0;
         instrucoes_q <= '0;
      end else begin
         case (estado)
            BUSCA: begin
               if (busca_q && instr_valida) begin
                  estado    <= EXECUTA;
                  busca_q   <= 1'b0;
                  executa_q <= 1'b1;
               end else begin
                  busca_q   <= 1'b1;
               end
            end
            EXECUTA: begin
               if (!pausa) begin
                  executa_q <= 1'b0;
                  if (instrucoes_q != 16'hFFFF) instrucoes_q <= instrucoes_q + 16'd1;
                  if (controle_ula == OP_PARAR) begin
                     estado   <= PARADO;
                     parado_q <= 1'b1;
                  end else begin
                     estado   <= BUSCA;
                     busca_q  <= 1'b1;
                     pc_q     <= pc_prox;
                  end
               end
            end
            default: begin
               busca_q   <= 1'b0;
               executa_q <= 1'b0;
               parado_q  <= 1'b1;
            end
         endcase
      end
   end

   assign pc         = pc_q;
   assign busca      = busca_q;
   assign executa    = executa_q;
   assign parado     = parado_q;
   assign instrucoes = instrucoes_q;

endmodule

// File: tb/tb_contador_de_programa.sv
// Scoreboard bench: each issued fetch queues its expected pc/count; a monitor checks every accepted fetch.
`timescale 1ns/1ps
module tb_contador_de_programa;
   import pacote_processador::*;

   localparam logic [4:0] OP_SOMA = 5'b00000;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [4:0]  controle_ula = '0;
   logic [15:0] branch = '0;
   logic [15:0] endereco_salto = '0;
   logic        salto = 1'b0;
   logic        chama = 1'b0;
   logic        retorna = 1'b0;
   logic        instr_valida = 1'b0;
   logic        pausa = 1'b0;
   logic [15:0] pc;
   logic        busca;
   logic        executa;
   logic        parado;
   logic        erro_pilha;
   logic [15:0] instrucoes;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] cnt;
   } esperado_t;

   esperado_t   fila[$];
   esperado_t   item_mon;
   int          checks = 0;
   int          errors = 0;
   int          n_exec = 0;
   logic [15:0] pc_r;
   logic [15:0] pc_h;

   contador_de_programa dut (
      .clock          (clock),
      .reset          (reset),
      .controle_ula   (controle_ula),
      .branch         (branch),
      .endereco_salto (endereco_salto),
      .salto          (salto),
      .chama          (chama),
      .retorna        (retorna),
      .instr_valida   (instr_valida),
      .pausa          (pausa),
      .pc             (pc),
      .busca          (busca),
      .executa        (executa),
      .parado         (parado),
      .erro_pilha     (erro_pilha),
      .instrucoes     (instrucoes)
   );

   always #5 clock = ~clock;

   task automatic verifica(input string nome, input logic [63:0] obtido, input logic [63:0] exigido);
      checks++;
      if (obtido !== exigido) begin
         errors++;
         $display("FAIL %s: obtido %h exigido %h", nome, obtido, exigido);
      end
   endtask

   always @(negedge clock) begin
      if (reset && busca && instr_valida) begin
         if (fila.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL busca_inesperada: pc %h aceito sem entrada na fila", pc);
         end else begin
            item_mon = fila.pop_front();
            verifica("busca_pc", 64'(pc), 64'(item_mon.pc));
            verifica("busca_instrucoes", 64'(instrucoes), 64'(item_mon.cnt));
         end
      end
   end

   task automatic espera_busca();
      int n = 0;
      while (!busca && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      checks++;
      if (!busca) begin
         errors++;
         $display("FAIL espera_busca: busca=%b apos %0d ciclos, exigido 1", busca, n);
      end
   endtask

   task automatic instr(input logic [4:0] op, input logic [15:0] br, input logic [15:0] alvo,
                        input logic sj, input logic ch, input logic rt, input int pausas,
                        input logic [15:0] pc_busca, input logic [15:0] pc_seg);
      esperado_t e;
      espera_busca();
      e.pc  = pc_busca;
      e.cnt = 16'(n_exec);
      fila.push_back(e);
      instr_valida = 1'b1;
      @(posedge clock); #1;
      instr_valida = 1'b0;
      verifica("executa_ativo", 64'({busca, executa}), 64'(2'b01));
      controle_ula   = op;
      branch         = br;
      endereco_salto = alvo;
      salto          = sj;
      chama          = ch;
      retorna        = rt;
      pausa          = (pausas > 0);
      for (int i = 0; i < pausas; i++) begin
         @(posedge clock); #1;
         verifica("pausa_congela", 64'({executa, pc, instrucoes}), 64'({1'b1, pc_busca, 16'(n_exec)}));
      end
      pausa = 1'b0;
      @(posedge clock); #1;
      controle_ula   = OP_SOMA;
      branch         = '0;
      endereco_salto = '0;
      salto          = 1'b0;
      chama          = 1'b0;
      retorna        = 1'b0;
      n_exec++;
      verifica("pc_seguinte", 64'(pc), 64'(pc_seg));
      verifica("instrucoes_apos", 64'(instrucoes), 64'(n_exec));
      verifica("executa_fim", 64'(executa), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulacao excedeu o limite de tempo");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      verifica("reset_estado", 64'({pc, busca, executa, parado, erro_pilha, instrucoes}),
               64'({16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
      reset = 1'b1;
      @(posedge clock); #1;
      verifica("busca_apos_reset", 64'(busca), 64'(1));

      instr(OP_SOMA, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0000, 16'h0001);
      instr(OP_SOMA, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0001, 16'h0002);
      instr(OP_SOMA, 16'h0, 16'h0, 0, 0, 0, 0, 16'h0002, 16'h0003);
      verifica("instrucoes_3", 64'(instrucoes), 64'(3));

      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         verifica("espera_memoria", 64'({busca, executa, pc, instrucoes}),
                  64'({1'b1, 1'b0, 16'h0003, 16'd3}));
      end

      instr(OP_BEQ,  16'h0040, 16'h0000, 0, 0, 0, 0, 16'h0003, 16'h0040);
      instr(OP_BEQ,  16'h0040, 16'h1234, 1, 0, 0, 0, 16'h0040, 16'h0040);
      instr(OP_BNE,  16'hFFFF, 16'h0000, 0, 0, 0, 0, 16'h0040, 16'hFFFF);
      instr(OP_SOMA, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'hFFFF, 16'h0000);
      verifica("sem_erro_wrap", 64'(erro_pilha), 64'(0));
      instr(OP_SOMA, 16'h0000, 16'h0200, 1, 0, 0, 0, 16'h0000, 16'h0200);
      instr(OP_SOMA, 16'h0000, 16'h0300, 0, 1, 0, 0, 16'h0200, 16'h0300);
`ifdef PILHA_RETORNO_EN
      pc_r = 16'h0201;
`else
      pc_r = 16'h0301;
`endif
      instr(OP_SOMA, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'h0300, pc_r);
      instr(OP_SOMA, 16'h0000, 16'h0000, 0, 0, 0, 3, pc_r, pc_r + 16'h0001);
      pc_h = pc_r + 16'h0001;

`ifdef PILHA_RETORNO_EN
      instr(OP_SOMA, 16'h0, 16'h0010, 1, 0, 0, 0, pc_h,     16'h0010);
      instr(OP_SOMA, 16'h0, 16'h0100, 0, 1, 0, 0, 16'h0010, 16'h0100);
      instr(OP_SOMA, 16'h0, 16'h0200, 0, 1, 0, 0, 16'h0100, 16'h0200);
      instr(OP_SOMA, 16'h0, 16'h0300, 0, 1, 0, 0, 16'h0200, 16'h0300);
      instr(OP_SOMA, 16'h0, 16'h0400, 0, 1, 0, 0, 16'h0300, 16'h0400);
      verifica("pilha_cheia_sem_erro", 64'(erro_pilha), 64'(0));
      instr(OP_SOMA, 16'h0, 16'h0500, 0, 1, 0, 0, 16'h0400, 16'h0500);
      verifica("erro_overflow", 64'(erro_pilha), 64'(1));
      instr(OP_SOMA, 16'h0, 16'h0000, 0, 0, 1, 0, 16'h0500, 16'h0301);
      instr(OP_SOMA, 16'h0, 16'h0000, 0, 0, 1, 0, 16'h0301, 16'h0201);
      instr(OP_SOMA, 16'h0, 16'h0000, 0, 0, 1, 0, 16'h0201, 16'h0101);
      instr(OP_SOMA, 16'h0, 16'h0000, 0, 0, 1, 0, 16'h0101, 16'h0011);
      instr(OP_SOMA, 16'h0, 16'h0000, 0, 0, 1, 0, 16'h0011, 16'h0012);
      verifica("erro_pegajoso", 64'(erro_pilha), 64'(1));
      pc_h = 16'h0012;
`else
      verifica("erro_desligado", 64'(erro_pilha), 64'(0));
`endif

      instr(OP_PARAR, 16'h0, 16'h0000, 0, 0, 0, 0, pc_h, pc_h);
      verifica("parado_ativo", 64'({parado, busca, executa}), 64'(3'b100));
      instr_valida   = 1'b1;
      salto          = 1'b1;
      endereco_salto = 16'h0777;
      for (int i = 0; i < 5; i++) begin
         @(posedge clock); #1;
         verifica("parado_congela", 64'({parado, busca, executa, pc, instrucoes}),
                  64'({3'b100, pc_h, 16'(n_exec)}));
      end
      instr_valida   = 1'b0;
      salto          = 1'b0;
      endereco_salto = '0;

      reset = 1'b0;
      @(posedge clock); #1;
      reset = 1'b1;
      verifica("reset_apos_parar", 64'({pc, busca, executa, parado, erro_pilha, instrucoes}),
               64'({16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}));
      n_exec = 0;
      instr(OP_SOMA, 16'h0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0001);

      repeat (2) @(posedge clock);
      #1;
      verifica("fila_vazia", 64'(fila.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
